// File: rtl/access_trace_buf_if.sv
// Access-stage probe and trace read-port bundle shared by access_trace_buf and its producer/consumer.
interface access_trace_buf_if;
  logic        stall;
  logic [63:0] pc;
  logic [4:0]  rd;
  logic [63:0] addr;
  logic [63:0] data;
  logic        request;
  logic        trap_en;
  logic [63:0] trap_pc;
  logic        rd_ready;
  logic        rd_valid;
  logic [63:0] rd_pc;
  logic [63:0] rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  rd_rd;
  logic        rd_trap;

  modport master (
    output stall, pc, rd, addr, data, request, trap_en, trap_pc, rd_ready,
    input  rd_valid, rd_pc, rd_addr, rd_data, rd_rd, rd_trap
  );

  modport slave (
    input  stall, pc, rd, addr, data, request, trap_en, trap_pc, rd_ready,
    output rd_valid, rd_pc, rd_addr, rd_data, rd_rd, rd_trap
  );
endinterface

// File: rtl/access_trace_buf.sv
// Filtered access trace ring buffer with arm/trap/post-trigger freeze control.
// Define ACCESS_TRACE_DISPLAY_EN to print every captured record and the freeze event.
module access_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm_i,
  input  logic                     flush_i,
  input  logic                     stop_on_full_i,
  input  logic [63:0]              flt_lo_i,
  input  logic [63:0]              flt_hi_i,
  access_trace_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              drops_o,
  output logic [1:0]               state_o,
  output logic                     triggered_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } state_e;

  state_e        state_q;
  logic [AW-1:0] headPtr_q, headPtr_d;
  logic [AW-1:0] tailPtr_q, tailPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] postCnt_q;
  logic [15:0]   drops_q, drops_d;
  logic          triggered_q;

  logic [63:0] memPc   [DEPTH];
  logic [63:0] memAddr [DEPTH];
  logic [63:0] memData [DEPTH];
  logic [4:0]  memRd   [DEPTH];
  logic        memTrap [DEPTH];

  logic inWindow, capEn, qual, full, popReq, doWrite, doDrop, trapHit;

  // An overwrite when full and not popping moves the head along with the tail.
  always_comb begin
    inWindow  = (bus.pc >= flt_lo_i) && (bus.pc <= flt_hi_i);
    capEn     = (state_q == ARMED) || (state_q == POST);
    qual      = (bus.request || bus.trap_en) && !bus.stall && inWindow && capEn && !flush_i;
    full      = (count_q == CW'(DEPTH));
    popReq    = bus.rd_ready && (count_q != '0);
    doWrite   = qual && (!full || popReq || !stop_on_full_i);
    doDrop    = qual && full && !popReq;
    trapHit   = qual && bus.trap_en;
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    drops_d   = drops_q;
    if (doWrite) tailPtr_d = tailPtr_q + 1'b1;
    if (popReq || (doDrop && !stop_on_full_i)) headPtr_d = headPtr_q + 1'b1;
    if (qual && !full && !popReq) count_d = count_q + 1'b1;
    else if (popReq && !qual) count_d = count_q - 1'b1;
    if (doDrop && (drops_q != 16'hFFFF)) drops_d = drops_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (doWrite) begin
      memPc[tailPtr_q]   <= bus.pc;
      memAddr[tailPtr_q] <= bus.addr;
      memData[tailPtr_q] <= bus.trap_en ? bus.trap_pc : bus.data;
      memRd[tailPtr_q]   <= bus.rd;
      memTrap[tailPtr_q] <= bus.trap_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      headPtr_q   <= '0;
      tailPtr_q   <= '0;
      count_q     <= '0;
      postCnt_q   <= '0;
      drops_q     <= '0;
      triggered_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      headPtr_q   <= '0;
      tailPtr_q   <= '0;
      count_q     <= '0;
      postCnt_q   <= '0;
      drops_q     <= '0;
      triggered_q <= 1'b0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
      drops_q   <= drops_d;
      // Trap records advance the FSM even when the record itself was discarded.
      case (state_q)
        IDLE, FROZEN: begin
          if (arm_i) begin
            state_q     <= ARMED;
            triggered_q <= 1'b0;
            postCnt_q   <= '0;
          end
        end
        ARMED: begin
          if (trapHit) begin
            triggered_q <= 1'b1;
            if (POST_TRIG == 0) begin
              state_q <= FROZEN;
            end else begin
              state_q   <= POST;
              postCnt_q <= CW'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (qual) begin
            postCnt_q <= postCnt_q - 1'b1;
            if (postCnt_q == CW'(1)) state_q <= FROZEN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_pc    = memPc[headPtr_q];
  assign bus.rd_addr  = memAddr[headPtr_q];
  assign bus.rd_data  = memData[headPtr_q];
  assign bus.rd_rd    = memRd[headPtr_q];
  assign bus.rd_trap  = memTrap[headPtr_q];

  assign count_o     = count_q;
  assign drops_o     = drops_q;
  assign state_o     = state_q;
  assign triggered_o = triggered_q;

`ifdef ACCESS_TRACE_DISPLAY_EN
  function automatic string abiName(input logic [4:0] r);
    string names [32];
    names = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
              "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
              "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
              "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
    return names[r];
  endfunction

  always_ff @(posedge clk) begin
    if (qual)
      $display("[access_trace_buf] %0t pc=%h rd=%s addr=%h data=%h trap=%0b",
               $time, bus.pc, abiName(bus.rd), bus.addr,
               bus.trap_en ? bus.trap_pc : bus.data, bus.trap_en);
    if (qual && (((state_q == ARMED) && bus.trap_en && (POST_TRIG == 0)) ||
                 ((state_q == POST) && (postCnt_q == CW'(1)))))
      $display("[access_trace_buf] %0t FROZEN count=%0d", $time, count_d);
  end
`else
  // Trace printing compiled out; capture behaviour is unaffected.
`endif

endmodule

// File: tb/tb_access_trace_buf.sv
// Directed scoreboard bench for access_trace_buf: fill/overwrite/drop, window filter, trigger freeze, reset and flush.
module tb_access_trace_buf;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;
  localparam logic [63:0] LO = 64'h0000_0000_8000_0000;
  localparam logic [63:0] HI = 64'h0000_0000_8000_FFFF;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] addr;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        trap;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0;
  logic flush = 1'b0;
  logic stopOnFull = 1'b0;
  logic [63:0] fltLo = LO;
  logic [63:0] fltHi = HI;
  logic [$clog2(DEPTH):0] count;
  logic [15:0] drops;
  logic [1:0]  state;
  logic        triggered;

  int vectors = 0;
  int miscompares = 0;
  int dropsExp = 0;
  rec_t sb[$];

  access_trace_buf_if bus();

  access_trace_buf #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .flush_i(flush),
    .stop_on_full_i(stopOnFull), .flt_lo_i(fltLo), .flt_hi_i(fltHi),
    .bus(bus), .count_o(count), .drops_o(drops), .state_o(state),
    .triggered_o(triggered)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelCapture(input rec_t r, input bit rdy);
    rec_t gone;
    if (rdy && sb.size() != 0) begin
      gone = sb.pop_front();
      sb.push_back(r);
    end else if (sb.size() < DEPTH) begin
      sb.push_back(r);
    end else if (stopOnFull) begin
      if (dropsExp < 65535) dropsExp++;
    end else begin
      gone = sb.pop_front();
      sb.push_back(r);
      if (dropsExp < 65535) dropsExp++;
    end
  endtask

  // One access-stage cycle; expectIn says whether the record should qualify.
  task automatic applyStimulus(input logic [63:0] pcv, input logic [4:0] rdv, input bit trap,
                               input logic [63:0] trapPcv, input bit stl, input bit rdy, input bit expectIn);
    rec_t r;
    r.pc   = pcv;
    r.addr = pcv ^ 64'h0000_1234_0000_0000;
    r.data = trap ? trapPcv : {pcv[31:0], ~pcv[31:0]};
    r.rd   = rdv;
    r.trap = trap;
    if (rdy && sb.size() != 0) checkOutput("pop_pc", bus.rd_pc, sb[0].pc);
    bus.pc       = pcv;
    bus.rd       = rdv;
    bus.addr     = r.addr;
    bus.data     = {pcv[31:0], ~pcv[31:0]};
    bus.trap_en  = trap;
    bus.request  = !trap;
    bus.trap_pc  = trapPcv;
    bus.stall    = stl;
    bus.rd_ready = rdy;
    @(negedge clk);
    bus.request  = 1'b0;
    bus.trap_en  = 1'b0;
    bus.stall    = 1'b0;
    bus.rd_ready = 1'b0;
    if (expectIn) modelCapture(r, rdy);
  endtask

  task automatic doArm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    dropsExp = 0;
  endtask

  task automatic drainAll();
    rec_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("rd_valid", 64'(bus.rd_valid), 64'd1);
      checkOutput("rd_pc", bus.rd_pc, e.pc);
      checkOutput("rd_addr", bus.rd_addr, e.addr);
      checkOutput("rd_data", bus.rd_data, e.data);
      checkOutput("rd_rd", 64'(bus.rd_rd), 64'(e.rd));
      checkOutput("rd_trap", 64'(bus.rd_trap), 64'(e.trap));
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
    end
    checkOutput("drained_count", 64'(count), 64'd0);
    checkOutput("drained_valid", 64'(bus.rd_valid), 64'd0);
  endtask

  initial begin
    bus.stall = 1'b0; bus.pc = '0; bus.rd = '0; bus.addr = '0; bus.data = '0;
    bus.request = 1'b0; bus.trap_en = 1'b0; bus.trap_pc = '0; bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 64'(state), 64'd0);
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_drops", 64'(drops), 64'd0);
    checkOutput("reset_trig", 64'(triggered), 64'd0);
    checkOutput("reset_valid", 64'(bus.rd_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] three in-window accesses after arm");
    doArm();
    for (int i = 0; i < 3; i++) applyStimulus(LO + 64'(4 * i), 5'(i + 1), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_count", 64'(count), 64'd3);
    checkOutput("t1_head_pc", bus.rd_pc, 64'h8000_0000);
    checkOutput("t1_state", 64'(state), 64'd1);
    drainAll();

    $display("[TB] overwrite mode, 20 captures");
    doFlush();
    stopOnFull = 1'b0;
    doArm();
    for (int i = 0; i < 20; i++) applyStimulus(LO + 64'h100 + 64'(4 * i), 5'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_count", 64'(count), 64'd16);
    checkOutput("t2_drops", 64'(drops), 64'd4);
    checkOutput("t2_drops_model", 64'(drops), 64'(dropsExp));
    checkOutput("t2_head_pc", bus.rd_pc, 64'h8000_0110);
    drainAll();

    $display("[TB] stop-on-full mode, 20 captures then full capture+pop");
    doFlush();
    stopOnFull = 1'b1;
    doArm();
    for (int i = 0; i < 20; i++) applyStimulus(LO + 64'h400 + 64'(4 * i), 5'(i + 7), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_count", 64'(count), 64'd16);
    checkOutput("t3_drops", 64'(drops), 64'd4);
    checkOutput("t3_head_pc", bus.rd_pc, 64'h8000_0400);
    applyStimulus(LO + 64'h500, 5'd9, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("t3_full_pop_count", 64'(count), 64'd16);
    checkOutput("t3_full_pop_drops", 64'(drops), 64'd4);
    checkOutput("t3_full_pop_head", bus.rd_pc, 64'h8000_0404);
    drainAll();

    $display("[TB] filter window, stall and empty pop");
    applyStimulus(LO - 64'd1, 5'd1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(HI + 64'd1, 5'd2, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(LO + 64'h20, 5'd3, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_filtered_count", 64'(count), 64'd0);
    applyStimulus(LO + 64'h300, 5'd4, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("t4_empty_pop_count", 64'(count), 64'd1);
    applyStimulus(HI, 5'd5, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(LO, 5'd6, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_edge_count", 64'(count), 64'd3);
    drainAll();

    $display("[TB] trap trigger and post-trigger freeze");
    doFlush();
    stopOnFull = 1'b0;
    doArm();
    applyStimulus(LO + 64'h200, 5'd10, 1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_triggered", 64'(triggered), 64'd1);
    checkOutput("t5_state_post", 64'(state), 64'd2);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(LO + 64'h200 + 64'(8 * i), 5'(i), 1'b0, '0, 1'b0, 1'b0, i <= 4);
      if (i == 3) checkOutput("t5_state_after3", 64'(state), 64'd2);
      if (i == 4) checkOutput("t5_state_after4", 64'(state), 64'd3);
    end
    checkOutput("t5_count", 64'(count), 64'd5);
    checkOutput("t5_trap_data", bus.rd_data, 64'h8000_1000);
    checkOutput("t5_trap_flag", 64'(bus.rd_trap), 64'd1);
    drainAll();
    doArm();
    checkOutput("t5_rearm_state", 64'(state), 64'd1);
    checkOutput("t5_rearm_trig", 64'(triggered), 64'd0);

    $display("[TB] async reset in POST, then flush");
    doFlush();
    doArm();
    for (int i = 0; i < 3; i++) applyStimulus(LO + 64'h600 + 64'(4 * i), 5'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(LO + 64'h610, 5'd11, 1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(LO + 64'h620 + 64'(4 * i), 5'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_count", 64'(count), 64'd7);
    checkOutput("t6_state", 64'(state), 64'd2);
    doArm();
    checkOutput("t6_arm_ignored", 64'(state), 64'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_count", 64'(count), 64'd0);
    checkOutput("t6_rst_state", 64'(state), 64'd0);
    checkOutput("t6_rst_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("t6_rst_trig", 64'(triggered), 64'd0);
    sb.delete();
    dropsExp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(LO + 64'h700, 5'd1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_no_arm_count", 64'(count), 64'd0);
    doArm();
    applyStimulus(LO + 64'h704, 5'd2, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(LO + 64'h708, 5'd3, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_rearm_count", 64'(count), 64'd2);
    doFlush();
    checkOutput("t6_flush_count", 64'(count), 64'd0);
    checkOutput("t6_flush_state", 64'(state), 64'd0);
    checkOutput("t6_flush_valid", 64'(bus.rd_valid), 64'd0);
    checkOutput("t6_flush_drops", 64'(drops), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/access_trace_buf.md
ACCESS_TRACE_BUF -- requirements
Module: access_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, 16, trace entries (power of 2, 4..256).
REQ-002 SHALL have parameter POST_TRIG, 4, records captured after trap trigger (0..DEPTH-1).
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port arm / flush  input  1 each  start capture / clear buffer.
REQ-006 SHALL have port stop_on_full  input  1  1=drop new records when full, 0=overwrite oldest.
REQ-007 SHALL have port flt_lo, flt_hi  input  64 each  inclusive unsigned PC filter window.
REQ-008 SHALL have ports stall 1, pc 64, rd 5, addr 64, data 64, request 1, trap_en 1, trap_pc 64, all inputs, from the access stage.
REQ-009 SHALL have port rd_ready  input  1  consumer pop request.
REQ-010 SHALL have port rd_valid  output  1  head entry present.
REQ-011 SHALL have ports rd_pc 64, rd_addr 64, rd_data 64, rd_rd 5, rd_trap 1, all outputs, holding the head entry.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  occupancy.
REQ-013 SHALL have port drops  output  16  saturating lost/overwritten record count.
REQ-014 SHALL have port state  output  2  FSM state; triggered  output  1  trap seen since arm.

Function
REQ-015 Qualifying event: (request|trap_en) & ~stall & flt_lo<=pc<=flt_hi, in state ARMED or POST only.
REQ-016 Record: pc, rd, addr, rd_trap=trap_en, data field = trap_en ? trap_pc : data.
REQ-017 Writes occur at the rising edge of the qualifying cycle; entry visible on rd_* the next cycle (latency 1).
REQ-018 rd_valid=(count!=0); rd_* driven from head slot; pop on rd_valid&rd_ready; rd_ready while empty is ignored.
REQ-019 States: IDLE=0, ARMED=1, POST=2, FROZEN=3.
REQ-020 IDLE/FROZEN --arm--> ARMED, triggered cleared, buffer contents kept.
REQ-021 ARMED: captured trap record sets triggered; POST_TRIG=0 -> FROZEN, else -> POST with post counter=POST_TRIG.
REQ-022 POST: each capture decrements post counter; capture bringing it to 0 -> FROZEN; further traps do not restart it.
REQ-023 arm in ARMED/POST is ignored.
REQ-024 Full and capture without pop: stop_on_full=1 -> record discarded, drops+1; stop_on_full=0 -> oldest overwritten, head advances, drops+1, count stays DEPTH.
REQ-025 Full with simultaneous capture and pop: pop oldest, write new, count unchanged, drops unchanged.
REQ-026 Non-full simultaneous capture and pop: count unchanged; empty with capture and rd_ready: no pop that cycle.
REQ-027 Discarded record containing a trap still triggers FSM per REQ-021/022.
REQ-028 drops saturates at 16'hFFFF; pointers wrap modulo DEPTH.
REQ-029 flush (priority over arm and capture): pointers, count, drops, triggered, post counter -> 0, state -> IDLE, next cycle.

Reset
REQ-030 rst_n low asynchronously: state=IDLE, count=0, drops=0, triggered=0, rd_valid=0, pointers 0; storage not reset.
REQ-031 Reset mid-capture or mid-POST discards all entries; first post-reset capture requires a new arm.

Configuration
REQ-032 Macro ACCESS_TRACE_DISPLAY_EN defined: each captured record prints $time, pc, abi_names[rd], addr, data, trap flag via $display, plus one line on FROZEN entry; undefined: no display code compiled, behaviour otherwise identical.

Verification
REQ-033 arm, 3 accesses pc=0x80000000..08 in window, rd_ready=0 -> count=3, rd_pc=0x80000000, state=ARMED.
REQ-034 DEPTH=16, stop_on_full=0, 20 captures -> count=16, drops=4, head pc = 5th record.
REQ-035 stop_on_full=1, 20 captures -> count=16, drops=4, head pc = 1st record.
REQ-036 POST_TRIG=4, trap_en with trap_pc=0x80001000 then 6 accesses -> triggered=1, FROZEN after 4th, count=5, trap entry rd_data=0x80001000.
REQ-037 Full buffer, capture and rd_ready same cycle -> count=16, drops unchanged; pc outside window, or stall=1 -> nothing captured.
REQ-038 rst_n low in POST with count=7 -> count=0, state=IDLE, rd_valid=0 immediately; flush -> same next cycle.
